serial_split: RTL and testbench

SERIAL_SPLIT -- requirements
Module: serial_split

---
 rtl/serial_split_pkg.sv | 20 ++
 rtl/serial_split.sv | 86 ++++++++
 tb/tb_serial_split.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_split_pkg.sv
// ============================================================================
// Module : serial_split_pkg
// Brief  : Shared constants and the level-width helper for serial_split.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_split_pkg;

    localparam int c_default_in  = 25;
    localparam int c_default_out = 12;

    // Width of the level counter: it must hold every value from 0 to IN+OUT.
    function automatic int calc_cw(input int in_w, input int out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_split.sv
// ============================================================================
// Module : serial_split
// Brief  : Bit-level width converter (IN-bit words in, OUT-bit words out, LSB
//          first). Optional macro SERIAL_SPLIT_FLUSH_EN adds a flush input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_split
    import serial_split_pkg::*;
#(
    parameter int IN  = c_default_in,
    parameter int OUT = c_default_out
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef SERIAL_SPLIT_FLUSH_EN
    input  logic                            flush,
`endif
    input  logic [IN-1:0]                   in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [OUT-1:0]                  out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [calc_cw(IN, OUT)-1:0]     level
);

    localparam int BUF = IN + OUT;
    localparam int CW  = calc_cw(IN, OUT);

    localparam logic [CW-1:0] c_out_lvl = CW'(OUT);
    localparam logic [CW-1:0] c_in_lvl  = CW'(IN);

    logic [BUF-1:0] r_buf;
    logic [CW-1:0]  r_level;

    logic [BUF-1:0] w_base_buf;
    logic [BUF-1:0] w_buf_nxt;
    logic [CW-1:0]  w_base_level;
    logic [CW-1:0]  w_level_nxt;
    logic           w_push;
    logic           w_pop;

    // All handshake outputs decode from registers only.
    assign in_ready  = (r_level <= c_out_lvl);
    assign out_valid = (r_level >= c_out_lvl);
    assign out       = r_buf[OUT-1:0];
    assign level     = r_level;

    always_comb begin
        w_push = in_valid && in_ready;
        w_pop  = out_valid && out_ready;

        // Pop first, so a same-cycle push lands directly above the survivors.
        w_base_buf   = w_pop ? (r_buf >> OUT) : r_buf;
        w_base_level = w_pop ? (r_level - c_out_lvl) : r_level;

        w_buf_nxt   = w_base_buf;
        w_level_nxt = w_base_level;

        if (w_push) begin
            w_buf_nxt   = w_base_buf | ({{OUT{1'b0}}, in} << w_base_level);
            w_level_nxt = w_base_level + c_in_lvl;
        end
`ifdef SERIAL_SPLIT_FLUSH_EN
        // Upper bits are already zero, so raising level pads the partial word.
        else if (flush && (r_level != '0) && (r_level < c_out_lvl)) begin
            w_level_nxt = c_out_lvl;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf   <= '0;
            r_level <= '0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_level <= w_level_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_split.sv
// ============================================================================
// Module : tb_serial_split
// Brief  : Self-checking bench for serial_split: bit-queue reference model,
//          directed cases and randomized traffic; optional flush coverage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_split;

    localparam int IN  = 25;
    localparam int OUT = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] in_w;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  level;
`ifdef SERIAL_SPLIT_FLUSH_EN
    logic        flush_s;
`endif

    // Reverse-ratio instance: 12-bit words in, 25-bit words out.
    logic [11:0] rev_in;
    logic        rev_in_valid;
    logic        rev_in_ready;
    logic [24:0] rev_out;
    logic        rev_out_valid;
    logic        rev_out_ready;
    logic [5:0]  rev_level;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model: the buffered bits in arrival order, oldest first.
    bit q[$];

    always #5 clk = ~clk;

    serial_split #(.IN(IN), .OUT(OUT)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_SPLIT_FLUSH_EN
        .flush     (flush_s),
`endif
        .in        (in_w),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    serial_split #(.IN(12), .OUT(25)) u_rev (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_SPLIT_FLUSH_EN
        .flush     (1'b0),
`endif
        .in        (rev_in),
        .in_valid  (rev_in_valid),
        .in_ready  (rev_in_ready),
        .out       (rev_out),
        .out_valid (rev_out_valid),
        .out_ready (rev_out_ready),
        .level     (rev_level)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  sz;
        bit  push;
        bit  pop;
        sz   = q.size();
        push = in_valid && (sz <= OUT);
        pop  = (sz >= OUT) && out_ready;
        if (pop)
            for (int i = 0; i < OUT; i++) void'(q.pop_front());
        if (push)
            for (int i = 0; i < IN; i++) q.push_back(in_w[i]);
`ifdef SERIAL_SPLIT_FLUSH_EN
        if (flush_s && !push && sz > 0 && sz < OUT)
            while (q.size() < OUT) q.push_back(1'b0);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) q.delete();
        else     model_step();
        #1;
    endtask

    // Asynchronous reset placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_level",     64'(level),     64'd0);
        check("rst_out",       64'(out),       64'd0);
        cycle();
        rst = 1'b0;
    endtask

    // Compare process: every cycle, DUT outputs against the bit queue.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] e_out;
            int          sz;
            sz    = q.size();
            e_out = '0;
            for (int i = 0; i < OUT; i++)
                if (i < sz) e_out[i] = q[i];
            check("model", {44'd0, out_valid, in_ready, level, out},
                  {44'd0, (sz >= OUT), (sz <= OUT), 6'(sz), e_out});
        end
    end

    initial begin
        rst           = 1'b1;
        in_w          = '0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        rev_in        = '0;
        rev_in_valid  = 1'b0;
        rev_out_ready = 1'b0;
`ifdef SERIAL_SPLIT_FLUSH_EN
        flush_s       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reverse ratio: three 12-bit words make one 25-bit word.
        for (int k = 1; k <= 3; k++) begin
            rev_in       = 12'(k);
            rev_in_valid = 1'b1;
            cycle();
        end
        rev_in_valid = 1'b0;
        check("rev_level36", 64'(rev_level),     64'd36);
        check("rev_out",     64'(rev_out),       64'h1002001);
        check("rev_valid",   64'(rev_out_valid), 64'd1);
        check("rev_inrdy",   64'(rev_in_ready),  64'd0);
        rev_out_ready = 1'b1;
        cycle();
        rev_out_ready = 1'b0;
        check("rev_level11", 64'(rev_level), 64'd11);

        // Split one word into two outputs plus a leftover bit.
        in_w = 25'h1234567; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("split_lvl25", 64'(level), 64'd25);
        check("split_out0",  64'(out),   64'h567);
        cycle();
        check("split_out1",  64'(out),   64'h234);
        cycle();
        check("split_lvl1",  64'(level), 64'd1);
        check("split_buf0",  64'(out),   64'h001);

`ifdef SERIAL_SPLIT_FLUSH_EN
        flush_s = 1'b1;
        cycle();
        flush_s = 1'b0;
        check("flush_out",   64'(out),       64'h001);
        check("flush_valid", 64'(out_valid), 64'd1);
        cycle();
        check("flush_lvl0",  64'(level),     64'd0);
`endif

        // Back-pressure: a single push, then the full buffer holds.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_w = 25'h1234567;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("bp_level", 64'(level),    64'd25);
            check("bp_inrdy", 64'(in_ready), 64'd0);
            check("bp_out",   64'(out),      64'h567);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("bp_release", 64'(out), 64'h234);

        // Walk the level to exactly OUT, then push and pop together.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 200 && q.size() != OUT; k++) begin
            in_w      = 25'($urandom);
            in_valid  = (q.size() < OUT);
            out_ready = (q.size() > OUT);
            cycle();
        end
        check("reach_lvl12", 64'(level), 64'd12);
        in_w = 25'($urandom); in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check("pushpop_lvl25", 64'(level), 64'd25);

        // Randomized traffic with occasional mid-stream resets.
        for (int k = 0; k < 1500; k++) begin
            in_w      = 25'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
`ifdef SERIAL_SPLIT_FLUSH_EN
            flush_s   = ($urandom_range(7) == 0);
`endif
            if (k % 250 == 249) do_reset();
            else                cycle();
        end

        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
